// File: rtl/hue_window_mask_if.sv
// Pixel stream carrying normalisable 10.6 hue values into the hue window mask.
// The producer drives the master side and the mask block listens on the slave side.
interface hue_window_mask_if;
    logic [15:0] data;
    logic        valid;
    logic        sof;
    logic        eof;

    modport master (output data, output valid, output sof, output eof);
    modport slave  (input  data, input  valid, input  sof, input  eof);
endinterface

// File: rtl/hue_window_mask.sv
// Hue window mask: classifies each hue pixel against a double-buffered window,
// counts masked pixels per frame and reports total plus detect flag at end of frame.
// Optional macro HUE_WINDOW_MASK_PASSTHRU_EN adds an o_data port carrying the
// normalised hue aligned with o_mask.
module hue_window_mask #(
    parameter int          COUNT_W = 20,
    parameter logic [15:0] DEF_LO  = 16'h0000,
    parameter logic [15:0] DEF_HI  = 16'h0F00
) (
    input  logic               i_clk,
    input  logic               i_rst,
    hue_window_mask_if.slave   pix,
    input  logic               i_cfg_wr,
    input  logic [15:0]        i_cfg_lo,
    input  logic [15:0]        i_cfg_hi,
    input  logic [COUNT_W-1:0] i_min_count,
    output logic               o_mask,
    output logic               o_valid,
    output logic               o_frame_done,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_detect
`ifdef HUE_WINDOW_MASK_PASSTHRU_EN
    ,
    output logic [15:0]        o_data
`endif
);

    localparam logic [15:0]        HUE_WRAP  = 16'h5A00;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [15:0]        shadow_lo;
    logic [15:0]        shadow_hi;
    logic [15:0]        active_lo;
    logic [15:0]        active_hi;

    logic [15:0]        hue_norm;
    logic               sof_accept;
    logic [15:0]        eff_lo;
    logic [15:0]        eff_hi;
    logic               ge_lo;
    logic               le_hi;
    logic               win_wrap;

    logic               s1_valid;
    logic               s1_sof;
    logic               s1_eof;
    logic               s1_ge_lo;
    logic               s1_le_hi;
    logic               s1_wrap;
`ifdef HUE_WINDOW_MASK_PASSTHRU_EN
    logic [15:0]        s1_hue;
`endif

    logic               s1_mask;
    logic [COUNT_W-1:0] counter;
    logic [COUNT_W-1:0] total;
    logic [COUNT_W-1:0] mask_ext;

    // Normalise hue and pick the bounds that apply to this pixel; an SOF pixel
    // sees the shadow values, or the freshly written ones when a write lands on it.
    always_comb begin
        hue_norm   = (pix.data >= HUE_WRAP) ? 16'h0000 : pix.data;
        sof_accept = pix.valid && pix.sof;
        eff_lo     = active_lo;
        eff_hi     = active_hi;
        if (sof_accept) begin
            if (i_cfg_wr) begin
                eff_lo = i_cfg_lo;
                eff_hi = i_cfg_hi;
            end else begin
                eff_lo = shadow_lo;
                eff_hi = shadow_hi;
            end
        end
        ge_lo    = (hue_norm >= eff_lo);
        le_hi    = (hue_norm <= eff_hi);
        win_wrap = (eff_lo > eff_hi);
    end

    // Shadow bounds take every config write; active bounds only move at SOF.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow_lo <= DEF_LO;
            shadow_hi <= DEF_HI;
            active_lo <= DEF_LO;
            active_hi <= DEF_HI;
        end else begin
            if (i_cfg_wr) begin
                shadow_lo <= i_cfg_lo;
                shadow_hi <= i_cfg_hi;
            end
            if (sof_accept) begin
                active_lo <= eff_lo;
                active_hi <= eff_hi;
            end
        end
    end

    // Stage 1 holds the two bound compares so stage 2 only has to combine them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_ge_lo <= 1'b0;
            s1_le_hi <= 1'b0;
            s1_wrap  <= 1'b0;
        end else begin
            s1_valid <= pix.valid;
            s1_sof   <= pix.valid && pix.sof;
            s1_eof   <= pix.valid && pix.eof;
            s1_ge_lo <= ge_lo;
            s1_le_hi <= le_hi;
            s1_wrap  <= win_wrap;
        end
    end

`ifdef HUE_WINDOW_MASK_PASSTHRU_EN
    // Normalised hue follows the compares so it lines up with o_mask.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_hue <= 16'h0000;
        end else begin
            s1_hue <= hue_norm;
        end
    end
`endif

    // A wrapping window (lo > hi) accepts either side of zero; otherwise both compares must hold.
    // The running total restarts at SOF and saturates instead of rolling over.
    always_comb begin
        s1_mask  = s1_wrap ? (s1_ge_lo || s1_le_hi) : (s1_ge_lo && s1_le_hi);
        mask_ext = {{(COUNT_W-1){1'b0}}, s1_mask};
        total    = counter;
        if (s1_sof) begin
            total = mask_ext;
        end else if (counter != COUNT_MAX) begin
            total = counter + mask_ext;
        end
    end

    // Stage 2 drives the mask outputs and closes out the frame on the EOF pixel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mask       <= 1'b0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_count      <= '0;
            o_detect     <= 1'b0;
            counter      <= '0;
        end else begin
            o_valid      <= s1_valid;
            o_mask       <= s1_valid && s1_mask;
            o_frame_done <= s1_valid && s1_eof;
            if (s1_valid) begin
                if (s1_eof) begin
                    o_count  <= total;
                    o_detect <= (total >= i_min_count);
                    counter  <= '0;
                end else begin
                    counter  <= total;
                end
            end
        end
    end

`ifdef HUE_WINDOW_MASK_PASSTHRU_EN
    // Pass the normalised hue out only while o_valid is high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data <= 16'h0000;
        end else begin
            o_data <= s1_valid ? s1_hue : 16'h0000;
        end
    end
`endif

endmodule

// File: tb/tb_hue_window_mask.sv
// Bench for hue_window_mask: a full-width instance and a 3-bit-counter instance
// share one pixel stream and are checked against a frame-level reference model.
module tb_hue_window_mask;

    logic        i_clk;
    logic        i_rst;
    logic        i_cfg_wr;
    logic [15:0] i_cfg_lo;
    logic [15:0] i_cfg_hi;
    logic [19:0] min_count;

    logic        m_mask, m_valid, m_done, m_detect;
    logic [19:0] m_count;
    logic        s_mask, s_valid, s_done, s_detect;
    logic [2:0]  s_count;
`ifdef HUE_WINDOW_MASK_PASSTHRU_EN
    logic [15:0] m_data;
    logic [15:0] s_data;
`endif

    hue_window_mask_if bus ();

    hue_window_mask #(.COUNT_W(20)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .pix(bus.slave),
        .i_cfg_wr(i_cfg_wr), .i_cfg_lo(i_cfg_lo), .i_cfg_hi(i_cfg_hi),
        .i_min_count(min_count),
        .o_mask(m_mask), .o_valid(m_valid), .o_frame_done(m_done),
        .o_count(m_count), .o_detect(m_detect)
`ifdef HUE_WINDOW_MASK_PASSTHRU_EN
        , .o_data(m_data)
`endif
    );

    hue_window_mask #(.COUNT_W(3)) dut_sat (
        .i_clk(i_clk), .i_rst(i_rst), .pix(bus.slave),
        .i_cfg_wr(i_cfg_wr), .i_cfg_lo(i_cfg_lo), .i_cfg_hi(i_cfg_hi),
        .i_min_count(min_count[2:0]),
        .o_mask(s_mask), .o_valid(s_valid), .o_frame_done(s_done),
        .o_count(s_count), .o_detect(s_detect)
`ifdef HUE_WINDOW_MASK_PASSTHRU_EN
        , .o_data(s_data)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        bit valid;
        bit mask;
        bit sof;
        bit eof;
        int hue;
    } pix_t;

    pix_t pipe[$];

    int tests_run = 0;
    int tests_failed = 0;

    int sh_lo, sh_hi, ac_lo, ac_hi;
    int run_main, run_sat;
    int exp_count_main, exp_count_sat;
    bit exp_det_main, exp_det_sat;

    function automatic bit modelMask(int h, int lo, int hi);
        if (lo <= hi) return (h >= lo) && (h <= hi);
        return (h >= lo) || (h <= hi);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic resetModel();
        pipe.delete();
        sh_lo = 0; sh_hi = 16'h0F00;
        ac_lo = 0; ac_hi = 16'h0F00;
        run_main = 0; run_sat = 0;
        exp_count_main = 0; exp_count_sat = 0;
        exp_det_main = 0; exp_det_sat = 0;
    endtask

    task automatic doReset();
        i_rst     = 1'b1;
        bus.valid = 1'b0;
        bus.sof   = 1'b0;
        bus.eof   = 1'b0;
        bus.data  = 16'h0000;
        i_cfg_wr  = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        resetModel();
        checkOutput("rst_valid",  32'(m_valid),  32'd0);
        checkOutput("rst_mask",   32'(m_mask),   32'd0);
        checkOutput("rst_done",   32'(m_done),   32'd0);
        checkOutput("rst_count",  32'(m_count),  32'd0);
        checkOutput("rst_detect", 32'(m_detect), 32'd0);
        checkOutput("rst_sat_count", 32'(s_count), 32'd0);
        checkOutput("rst_sat_done",  32'(s_done),  32'd0);
        i_rst = 1'b0;
        pipe.push_back('{valid: 1'b0, mask: 1'b0, sof: 1'b0, eof: 1'b0, hue: 0});
    endtask

    // Drives one cycle, then compares both instances against the pixel two cycles back.
    task automatic applyStimulus(input bit v, input int d, input bit s, input bit e,
                                 input bit w = 1'b0, input int lo = 0, input int hi = 0);
        pix_t cur;
        pix_t old;
        int   h;
        int   use_lo;
        int   use_hi;
        bit   done;
        int   tot_m;
        int   tot_s;

        bus.valid = v;
        bus.data  = d[15:0];
        bus.sof   = s;
        bus.eof   = e;
        i_cfg_wr  = w;
        i_cfg_lo  = lo[15:0];
        i_cfg_hi  = hi[15:0];

        h = (d >= 16'h5A00) ? 0 : d;
        if (v && s) begin
            use_lo = w ? lo : sh_lo;
            use_hi = w ? hi : sh_hi;
            ac_lo  = use_lo;
            ac_hi  = use_hi;
        end
        if (w) begin
            sh_lo = lo;
            sh_hi = hi;
        end
        cur.valid = v;
        cur.mask  = modelMask(h, ac_lo, ac_hi);
        cur.sof   = v && s;
        cur.eof   = v && e;
        cur.hue   = h;
        pipe.push_back(cur);

        @(posedge i_clk);
        #1;

        old  = pipe.pop_front();
        done = 1'b0;
        if (old.valid) begin
            tot_m = old.sof ? int'(old.mask) : run_main + int'(old.mask);
            tot_s = old.sof ? int'(old.mask) : run_sat + int'(old.mask);
            if (tot_s > 7) tot_s = 7;
            if (old.eof) begin
                done           = 1'b1;
                exp_count_main = tot_m;
                exp_count_sat  = tot_s;
                exp_det_main   = (tot_m >= int'(min_count));
                exp_det_sat    = (tot_s >= int'(min_count[2:0]));
                run_main       = 0;
                run_sat        = 0;
            end else begin
                run_main = tot_m;
                run_sat  = tot_s;
            end
        end

        checkOutput("valid",      32'(m_valid),  32'(old.valid));
        checkOutput("mask",       32'(m_mask),   32'(old.valid && old.mask));
        checkOutput("frame_done", 32'(m_done),   32'(done));
        checkOutput("count",      32'(m_count),  32'(exp_count_main));
        checkOutput("detect",     32'(m_detect), 32'(exp_det_main));
        checkOutput("sat_mask",   32'(s_mask),   32'(old.valid && old.mask));
        checkOutput("sat_done",   32'(s_done),   32'(done));
        checkOutput("sat_count",  32'(s_count),  32'(exp_count_sat));
        checkOutput("sat_detect", 32'(s_detect), 32'(exp_det_sat));
`ifdef HUE_WINDOW_MASK_PASSTHRU_EN
        checkOutput("data",       32'(m_data),   old.valid ? 32'(old.hue) : 32'd0);
`endif
    endtask

    initial begin
        int rd;
        int rlo;
        int rhi;
        i_rst     = 1'b1;
        i_cfg_wr  = 1'b0;
        i_cfg_lo  = 16'h0000;
        i_cfg_hi  = 16'h0000;
        min_count = 20'd4;
        bus.valid = 1'b0;
        bus.sof   = 1'b0;
        bus.eof   = 1'b0;
        bus.data  = 16'h0000;

        $display("[TB] reset and default window");
        doReset();
        applyStimulus(1, 16'h0000, 0, 0);
        applyStimulus(1, 16'h0F00, 0, 0);
        applyStimulus(1, 16'h0F01, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] wrapping red window written on the sof pixel");
        applyStimulus(1, 16'h5A00, 1, 0, 1, 16'h5280, 16'h0780);
        applyStimulus(1, 16'h5300, 0, 0);
        applyStimulus(1, 16'h0780, 0, 0);
        applyStimulus(1, 16'h2000, 0, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] ten pixel frames, thresholds 4 then 5");
        for (int f = 0; f < 2; f++) begin
            min_count = (f == 0) ? 20'd4 : 20'd5;
            applyStimulus(1, 16'h0100, 1, 0);
            applyStimulus(1, 16'h1000, 0, 0);
            applyStimulus(1, 16'h5400, 0, 0);
            applyStimulus(1, 16'h2000, 0, 0);
            applyStimulus(1, 16'h0000, 0, 0);
            applyStimulus(1, 16'h3000, 0, 0);
            applyStimulus(1, 16'h4000, 0, 0);
            applyStimulus(1, 16'h5000, 0, 0);
            applyStimulus(1, 16'h0800, 0, 0);
            applyStimulus(1, 16'h0780, 0, 1);
            applyStimulus(0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0);
        end

        $display("[TB] mid-frame config write");
        min_count = 20'd1;
        applyStimulus(1, 16'h0100, 1, 0);
        applyStimulus(1, 16'h5400, 0, 0);
        applyStimulus(1, 16'h0000, 0, 0, 1, 16'h5000, 16'h5000);
        applyStimulus(1, 16'h1000, 0, 0);
        applyStimulus(1, 16'h0780, 0, 1);
        applyStimulus(1, 16'h0100, 1, 0);
        applyStimulus(1, 16'h0000, 0, 1);
        applyStimulus(1, 16'h5000, 1, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] reset mid-frame");
        applyStimulus(1, 16'h5000, 1, 0);
        applyStimulus(1, 16'h5000, 0, 0);
        doReset();
        applyStimulus(1, 16'h0100, 1, 0);
        applyStimulus(1, 16'h0200, 0, 0);
        applyStimulus(1, 16'h2000, 0, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] nine in-window pixels for saturation");
        min_count = 20'd8;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 16'h0100 + i, (i == 0), (i == 8));
        end
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] randomised traffic");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) min_count = 20'($urandom_range(0, 10));
            rd  = int'($urandom_range(0, 16'h5FFF));
            rlo = int'($urandom_range(0, 16'h59FF));
            rhi = int'($urandom_range(0, 16'h59FF));
            applyStimulus($urandom_range(0, 3) != 0, rd,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 19) == 0, rlo, rhi);
        end
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
